seven_seg_scan: RTL and testbench
=================================

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 The block SHALL have parameter DIV, default 8, giving the clock cycles per digit slot; legal range 2..65535.
REQ-002 The block SHALL have parameter BLANK, default 2, giving the blanked cycles at the start of each slot; legal range 0..DIV-1.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port en  input  1  scan enable; low = display dark.
REQ-006 Port seg, seg2, seg3, seg4  input  7 each  active-low segment patterns for digits 0..3 (bit 6 = segment a).
REQ-007 Port seg_out  output  7  shared active-low segment bus.
REQ-008 Port an  output  4  active-low digit anodes; an[k] selects digit k.
REQ-009 Port digit  output  2  index of the current slot.
REQ-010 Port frame_tick  output  1  one-cycle pulse marking the end of a full 4-digit frame.

Function
REQ-011 The block SHALL hold a slot counter cnt (width clog2(DIV)) and a slot index digit (0..3).
REQ-012 The block SHALL hold four 7-bit snapshot registers snap0..snap3; seg_out SHALL be driven only from snapshots, never directly from the inputs.
REQ-013 When en=1, cnt SHALL increment each cycle; at DIV-1 it SHALL wrap to 0, and digit SHALL advance 0->1->2->3->0 on that same edge.
REQ-014 When en=0, cnt and digit SHALL be forced to 0 on each edge, and snap0..3 SHALL load seg..seg4 on every edge.
REQ-015 When en=1, snap0..3 SHALL load seg..seg4 only on the edge where digit=3 and cnt=DIV-1 (frame wrap); input changes mid-frame SHALL NOT appear until the next frame.
REQ-016 seg_out, an, digit and frame_tick SHALL be registered and SHALL update on the same edge as cnt/digit, so they always describe the current cnt/digit.
REQ-017 When en=1 and cnt<BLANK: an=4'b1111 and seg_out=7'b1111111 (blanking, anti-ghost).
REQ-018 When en=1 and cnt>=BLANK: an SHALL have exactly bit [digit] low, and seg_out SHALL equal snap[digit].
REQ-019 When en=0: an=4'b1111 and seg_out=7'b1111111.
REQ-020 frame_tick SHALL be 1 exactly during the cycle in which digit=3, cnt=DIV-1 and en=1, and 0 otherwise.
REQ-021 With BLANK=0, the blanking phase SHALL be absent and each digit SHALL be lit for all DIV cycles of its slot.
REQ-022 If en falls mid-slot, the next edge SHALL blank outputs and zero cnt/digit.
REQ-023 On en rising, scanning SHALL start at digit 0, cnt 0, using the snapshot loaded on the last en=0 edge.
REQ-024 At most one an bit SHALL be low in any cycle.
REQ-025 No glitch SHALL exist between digits: an SHALL pass through 4'b1111 for BLANK cycles whenever BLANK>0.

Reset
REQ-026 rst=1 SHALL immediately force cnt=0, digit=0, an=4'b1111, seg_out=7'b1111111, frame_tick=0, and snap0..3=7'b1111111, without waiting for clk.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release the block SHALL behave per REQ-014/REQ-023.

Verification (DIV=8, BLANK=2)
REQ-028 Reset with inputs 0000001/1001111/0010010/0000110 and en=1 from release -> the first frame shows blank; at frame wrap, snapshots load; the next frame shows digit 0 with an=1110 and seg_out=0000001 at cnt 2..7, then digit 1 with an=1101 and seg_out=1001111, and so on.
REQ-029 Steady scan -> frame_tick pulses once every 32 cycles, and an is 1111 at cnt 0..1 of every slot.
REQ-030 seg2 changed from 1001111 to 0100100 while digit=2 -> digit 1 keeps 1001111 until the wrap; the next frame shows 0100100.
REQ-031 en dropped at digit=2, cnt=5 -> the next edge gives an=1111, seg_out=1111111, digit=0; en raised again -> the scan restarts at digit 0 with the current inputs.
REQ-032 rst asserted asynchronously mid-cycle during digit 3 lit -> an=1111 and seg_out=1111111 before the next clk edge, and frame_tick never pulses.
REQ-033 BLANK=0 -> an is never 1111 while en=1, and each digit is lit for 8 consecutive cycles.

Source files
------------

// File: rtl/seven_seg_scan_if.sv
// rtl/seven_seg_scan_if.sv - display scan interface: enable, digit patterns in, multiplexed drive out
interface seven_seg_scan_if;
    logic       en;
    logic [6:0] seg;
    logic [6:0] seg2;
    logic [6:0] seg3;
    logic [6:0] seg4;
    logic [6:0] seg_out;
    logic [3:0] an;
    logic [1:0] digit;
    logic       frame_tick;

    modport master (
        output en, seg, seg2, seg3, seg4,
        input  seg_out, an, digit, frame_tick
    );

    modport slave (
        input  en, seg, seg2, seg3, seg4,
        output seg_out, an, digit, frame_tick
    );
endinterface

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - four-digit multiplexed seven-segment scanner with per-slot blanking
module seven_seg_scan #(
    parameter int DIV   = 8,
    parameter int BLANK = 2
) (
    input  logic            clk,
    input  logic            rst,
    seven_seg_scan_if.slave bus
);
    localparam int             CW      = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0]  BLANK_C = CW'(BLANK);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [1:0]    digit;
    logic [1:0]    digit_n;
    logic [6:0]    snap   [4];
    logic [6:0]    snap_n [4];
    logic [6:0]    seg_in [4];
    logic          load;
    logic          lit;
    logic [6:0]    seg_out_r;
    logic [6:0]    seg_out_n;
    logic [3:0]    an_r;
    logic [3:0]    an_n;
    logic          tick_r;
    logic          tick_n;

    assign seg_in[0] = bus.seg;
    assign seg_in[1] = bus.seg2;
    assign seg_in[2] = bus.seg3;
    assign seg_in[3] = bus.seg4;

    // Blanking window at the head of each slot suppresses ghosting; absent when BLANK is 0.
    generate
        if (BLANK == 0) begin : g_no_blank
            assign lit = 1'b1;
        end else begin : g_blank
            assign lit = (cnt_n >= BLANK_C);
        end
    endgenerate

    // Next slot position and snapshot: patterns are captured only while dark or at the frame wrap.
    always_comb begin
        cnt_n   = cnt;
        digit_n = digit;
        load    = 1'b0;
        if (!bus.en) begin
            cnt_n   = '0;
            digit_n = 2'd0;
            load    = 1'b1;
        end else if (cnt == CNT_MAX) begin
            cnt_n   = '0;
            digit_n = digit + 2'd1;
            load    = (digit == 2'd3);
        end else begin
            cnt_n   = cnt + CW'(1);
        end
        for (int k = 0; k < 4; k++) begin
            snap_n[k] = load ? seg_in[k] : snap[k];
        end
    end

    // Outputs are derived from the next state so the registered drive matches the registered cnt/digit.
    always_comb begin
        an_n      = 4'b1111;
        seg_out_n = 7'b1111111;
        tick_n    = 1'b0;
        if (bus.en) begin
            if (lit) begin
                an_n      = ~(4'b0001 << digit_n);
                seg_out_n = snap_n[digit_n];
            end
            tick_n = (digit_n == 2'd3) && (cnt_n == CNT_MAX);
        end
    end

    // State and output registers; reset darkens the display immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            digit     <= 2'd0;
            an_r      <= 4'b1111;
            seg_out_r <= 7'b1111111;
            tick_r    <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                snap[k] <= 7'b1111111;
            end
        end else begin
            cnt       <= cnt_n;
            digit     <= digit_n;
            an_r      <= an_n;
            seg_out_r <= seg_out_n;
            tick_r    <= tick_n;
            for (int k = 0; k < 4; k++) begin
                snap[k] <= snap_n[k];
            end
        end
    end

    assign bus.seg_out    = seg_out_r;
    assign bus.an         = an_r;
    assign bus.digit      = digit;
    assign bus.frame_tick = tick_r;
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - directed self-checking bench for seven_seg_scan (BLANK=2 and BLANK=0)
module tb_seven_seg_scan;
    logic       clk;
    logic       rst;
    logic       en;
    logic [6:0] s0, s1, s2, s3;

    int n_cmp;
    int n_bad;
    int ticks;
    int dark1;
    int ticks_saved;

    int         mc;
    int         md;
    logic [6:0] ms [4];

    seven_seg_scan_if bus0 ();
    seven_seg_scan_if bus1 ();

    assign bus0.en   = en;
    assign bus0.seg  = s0;
    assign bus0.seg2 = s1;
    assign bus0.seg3 = s2;
    assign bus0.seg4 = s3;
    assign bus1.en   = en;
    assign bus1.seg  = s0;
    assign bus1.seg2 = s1;
    assign bus1.seg3 = s2;
    assign bus1.seg4 = s3;

    seven_seg_scan #(.DIV(8), .BLANK(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    seven_seg_scan #(.DIV(8), .BLANK(0)) u_dut_nb (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    // One clock edge: advance the reference scan, then compare both instances after the edge.
    task automatic step();
        logic       e;
        logic [3:0] xa0, xa1;
        logic [6:0] xs0, xs1;
        logic       xt;
        e = en;
        if (rst) begin
            mc = 0;
            md = 0;
            for (int k = 0; k < 4; k++) ms[k] = 7'h7f;
        end else if (!e) begin
            mc = 0;
            md = 0;
            ms[0] = s0; ms[1] = s1; ms[2] = s2; ms[3] = s3;
        end else if (mc == 7) begin
            if (md == 3) begin
                ms[0] = s0; ms[1] = s1; ms[2] = s2; ms[3] = s3;
            end
            mc = 0;
            md = (md + 1) % 4;
        end else begin
            mc = mc + 1;
        end
        xa0 = 4'hf; xs0 = 7'h7f; xa1 = 4'hf; xs1 = 7'h7f; xt = 1'b0;
        if (!rst && e) begin
            xa1 = ~(4'b0001 << md);
            xs1 = ms[md];
            if (mc >= 2) begin
                xa0 = xa1;
                xs0 = xs1;
            end
            xt = (md == 3) && (mc == 7);
        end
        @(posedge clk);
        #1;
        expect_eq("an", {28'd0, bus0.an}, {28'd0, xa0});
        expect_eq("seg_out", {25'd0, bus0.seg_out}, {25'd0, xs0});
        expect_eq("digit", {30'd0, bus0.digit}, md);
        expect_eq("frame_tick", {31'd0, bus0.frame_tick}, {31'd0, xt});
        expect_eq("nb_an", {28'd0, bus1.an}, {28'd0, xa1});
        expect_eq("nb_seg_out", {25'd0, bus1.seg_out}, {25'd0, xs1});
        if (bus0.frame_tick) ticks++;
        if (e && !rst && bus1.an == 4'hf) dark1++;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; ticks = 0; dark1 = 0;
        rst = 1'b1;
        en  = 1'b1;
        s0 = 7'b0000001; s1 = 7'b1001111; s2 = 7'b0010010; s3 = 7'b0000110;
        mc = 0; md = 0;
        for (int k = 0; k < 4; k++) ms[k] = 7'h7f;

        #12;
        expect_eq("rst_an", {28'd0, bus0.an}, 32'hf);
        expect_eq("rst_seg_out", {25'd0, bus0.seg_out}, 32'h7f);
        expect_eq("rst_digit", {30'd0, bus0.digit}, 32'd0);
        expect_eq("rst_tick", {31'd0, bus0.frame_tick}, 32'd0);

        @(posedge clk);
        #1;
        rst = 1'b0;

        repeat (34) step();
        expect_eq("f1_d0_an", {28'd0, bus0.an}, 32'b1110);
        expect_eq("f1_d0_seg", {25'd0, bus0.seg_out}, 32'b0000001);
        repeat (8) step();
        expect_eq("f1_d1_an", {28'd0, bus0.an}, 32'b1101);
        expect_eq("f1_d1_seg", {25'd0, bus0.seg_out}, 32'b1001111);
        repeat (22) step();
        expect_eq("tick_count", ticks, 32'd2);

        repeat (16) step();
        s1 = 7'b0100100;
        repeat (26) step();
        expect_eq("new_frame_d1_seg", {25'd0, bus0.seg_out}, 32'b0100100);
        expect_eq("new_frame_d1_an", {28'd0, bus0.an}, 32'b1101);

        repeat (11) step();
        expect_eq("pre_drop_digit", {30'd0, bus0.digit}, 32'd2);
        en = 1'b0;
        s0 = 7'b1111000;
        step();
        expect_eq("drop_an", {28'd0, bus0.an}, 32'hf);
        expect_eq("drop_seg", {25'd0, bus0.seg_out}, 32'h7f);
        expect_eq("drop_digit", {30'd0, bus0.digit}, 32'd0);
        repeat (3) step();
        en = 1'b1;
        repeat (2) step();
        expect_eq("restart_an", {28'd0, bus0.an}, 32'b1110);
        expect_eq("restart_seg", {25'd0, bus0.seg_out}, 32'b1111000);

        repeat (26) step();
        expect_eq("d3_lit_an", {28'd0, bus0.an}, 32'b0111);
        ticks_saved = ticks;
        #2;
        rst = 1'b1;
        #1;
        expect_eq("async_an", {28'd0, bus0.an}, 32'hf);
        expect_eq("async_seg", {25'd0, bus0.seg_out}, 32'h7f);
        expect_eq("async_digit", {30'd0, bus0.digit}, 32'd0);
        expect_eq("async_tick", {31'd0, bus0.frame_tick}, 32'd0);
        repeat (6) step();
        rst = 1'b0;
        expect_eq("no_tick_in_reset", ticks, ticks_saved);
        repeat (40) step();
        expect_eq("nb_never_dark", dark1, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
